// File: rtl/serial_alu32.sv
// -----------------------------------------------------------------------------
// serial_alu32
//   Bit-serial WIDTH-bit ALU. A single 1-bit ALU slice is walked LSB-first over
//   the operands, one bit per clock, with the ripple carry held in a flop.
//   This is the small, slow counterpart to the combinational datapath ALU.
//   Op encoding (same as the 1-bit slice):
//     000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
//   Any other encoding runs for the full latency and returns zero.
//   The caller uses a start/busy/done handshake. done pulses WIDTH+1 edges
//   after the edge that accepts start.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request; sampled only while busy=0
//   a, b, op  operands and operation; captured when start is accepted
//   busy      operation in progress
//   done      one-cycle pulse; result and flags are valid
//   result    result; held until the next accepted operation completes
//   zero      result == 0
//   c_out     carry out of the MSB (ADD/SUB only)
//   overflow  signed overflow (ADD/SUB only)
// -----------------------------------------------------------------------------
module serial_alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             c_out,
  output logic             overflow
);

  localparam int              IDXW     = $clog2(WIDTH);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;

  logic             b_inv;
  logic             slice_b;
  logic             slice_sum;
  logic             slice_cout;
  logic             arith_ovf;
  logic [WIDTH-1:0] fin_result;
  logic             fin_c_out;
  logic             fin_overflow;

  // SUB and SLT compute a + ~b + 1. The +1 comes from the initial carry.
  assign b_inv   = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign slice_b = b_q[0] ^ b_inv;

  // One bit of the ALU slice, applied to the current LSBs of the shift registers
  always_comb begin
    slice_sum  = 1'b0;
    slice_cout = 1'b0;
    case (op_q)
      OP_AND: slice_sum = a_q[0] & slice_b;
      OP_OR:  slice_sum = a_q[0] | slice_b;
      OP_ADD, OP_SUB, OP_SLT: begin
        slice_sum  = a_q[0] ^ slice_b ^ carry_q;
        slice_cout = (a_q[0] & slice_b) | (a_q[0] & carry_q) | (slice_b & carry_q);
      end
      default: begin
        slice_sum  = 1'b0;
        slice_cout = 1'b0;
      end
    endcase
  end

  // Format the final result and flags from the serial sum and the MSB carries
  always_comb begin
    arith_ovf    = msb_cin_q ^ carry_q;
    fin_result   = '0;
    fin_c_out    = 1'b0;
    fin_overflow = 1'b0;
    case (op_q)
      OP_AND, OP_OR: fin_result = sum_q;
      OP_ADD, OP_SUB: begin
        fin_result   = sum_q;
        fin_c_out    = carry_q;
        fin_overflow = arith_ovf;
      end
      // The sign of a-b, corrected for overflow, gives the signed less-than result.
      OP_SLT: fin_result = {{(WIDTH-1){1'b0}}, sum_q[WIDTH-1] ^ arith_ovf};
      default: begin
        fin_result   = '0;
        fin_c_out    = 1'b0;
        fin_overflow = 1'b0;
      end
    endcase
  end

  // Control FSM next-state and datapath next values
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    op_d       = op_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    msb_cin_d  = msb_cin_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = (op == OP_SUB) || (op == OP_SLT);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // Operands shift right. Sum bits enter at the MSB, so bit 0 ends at position 0.
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {slice_sum, sum_q[WIDTH-1:1]};
        carry_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          msb_cin_d = carry_q;
          idx_d     = '0;
          state_d   = ST_FIN;
        end else begin
          idx_d     = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
        end
      end
      ST_FIN: begin
        result_d   = fin_result;
        zero_d     = (fin_result == '0);
        c_out_d    = fin_c_out;
        overflow_d = fin_overflow;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      op_q       <= 3'b000;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      msb_cin_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      msb_cin_q  <= msb_cin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign c_out    = c_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_alu32.sv
// -----------------------------------------------------------------------------
// tb_serial_alu32
//   Directed self-checking bench for serial_alu32 (WIDTH=32). Stimulus is
//   driven on the falling clock edge and outputs are sampled there too. The
//   expected values are computed by hand.
// -----------------------------------------------------------------------------
module tb_serial_alu32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        c_out;
  logic        overflow;

  int n_assert;
  int n_fail;

  serial_alu32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns the number of edges from the accepting edge to the edge that raised done.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [2:0] top, input logic [31:0] er,
                        input logic ez, input logic ec, input logic ev);
    int lat;
    @(negedge clk);
    a = ta; b = tbv; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk({tag, ".latency"}, 32'(lat), 32'd33);
    chk({tag, ".result"},  result, er);
    chk({tag, ".zero"},    32'(zero), 32'(ez));
    chk({tag, ".c_out"},   32'(c_out), 32'(ec));
    chk({tag, ".ovf"},     32'(overflow), 32'(ev));
    @(negedge clk);
    chk({tag, ".done_1cyc"}, 32'(done), 32'd0);
    chk({tag, ".idle"},      32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    logic done_seen;
    n_assert = 0;
    n_fail   = 0;

    // 1. Reset held with random inputs and start asserted.
    rst_n = 1'b0; start = 1'b1;
    a = $urandom; b = $urandom; op = 3'($urandom_range(7, 0));
    repeat (3) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 3'($urandom_range(7, 0));
    end
    chk("rst.busy",   32'(busy), 32'd0);
    chk("rst.done",   32'(done), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.zero",   32'(zero), 32'd0);
    chk("rst.c_out",  32'(c_out), 32'd0);
    chk("rst.ovf",    32'(overflow), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    // 2-4. Directed arithmetic and logic operations.
    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b0, 1'b1);
    run_op("sub_5_7",  32'h00000005, 32'h00000007, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_7_5",  32'h00000007, 32'h00000005, 3'b110, 32'h00000002, 1'b0, 1'b1, 1'b0);
    run_op("slt_5_7",  32'h00000005, 32'h00000007, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op("slt_7_5",  32'h00000007, 32'h00000005, 3'b111, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op("slt_ovf",  32'h80000000, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op("and",      32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
    run_op("or",       32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    run_op("undef",    32'h0000FFFF, 32'h00000001, 3'b100, 32'h00000000, 1'b1, 1'b0, 1'b0);

    // 5. start pulses while busy are ignored; start in the done cycle is accepted.
    @(negedge clk);
    a = 32'h00000001; b = 32'h00000002; op = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      start = (lat == 5) || (lat == 20);
      if (start) begin
        a = 32'hDEAD0000; b = 32'h0000BEEF; op = 3'b110;
      end
      if (lat == 20) chk("b2b.hold_while_busy", result, 32'h00000000);
    end
    chk("b2b.latency", 32'(lat), 32'd33);
    chk("b2b.first_result", result, 32'h00000003);
    a = 32'h0000FFFF; b = 32'hFFFF0000; op = 3'b001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.accepted_busy", 32'(busy), 32'd1);
    chk("b2b.done_dropped",  32'(done), 32'd0);
    wait_done(lat);
    chk("b2b.second_latency", 32'(lat), 32'd33);
    chk("b2b.second_result",  result, 32'hFFFFFFFF);
    chk("b2b.second_zero",    32'(zero), 32'd0);

    // 6. Reset in the middle of an ADD discards it; a fresh op then completes.
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; op = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy",   32'(busy), 32'd0);
    chk("midrst.done",   32'(done), 32'd0);
    chk("midrst.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    chk("midrst.no_done", 32'(done_seen), 32'd0);
    run_op("post_rst_add", 32'h12345678, 32'h11111111, 3'b010, 32'h23456789, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
